// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite initiator driven by a cmd/rsp valid-ready pair,
// with a saturating count of non-OKAY responses.
module axil_lite_master #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ERRCNT_W-1:0]   err_count,
    output logic [ADDR_W-1:0]     M_AXI_awaddr,
    output logic [2:0]            M_AXI_awprot,
    output logic                  M_AXI_awvalid,
    input  logic                  M_AXI_awready,
    output logic [DATA_W-1:0]     M_AXI_wdata,
    output logic [DATA_W/8-1:0]   M_AXI_wstrb,
    output logic                  M_AXI_wvalid,
    input  logic                  M_AXI_wready,
    input  logic [1:0]            M_AXI_bresp,
    input  logic                  M_AXI_bvalid,
    output logic                  M_AXI_bready,
    output logic [ADDR_W-1:0]     M_AXI_araddr,
    output logic [2:0]            M_AXI_arprot,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [DATA_W-1:0]     M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready
);
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ_AR, WAIT_R, RESP} state_t;

    state_t                state, nxt;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wr, awv, wv;
    logic                  b_hs, r_hs, cap;
    logic [1:0]            cap_resp;

    assign b_hs     = state == WAIT_B && M_AXI_bvalid;
    assign r_hs     = state == WAIT_R && M_AXI_rvalid;
    assign cap      = b_hs || r_hs;
    assign cap_resp = b_hs ? M_AXI_bresp : M_AXI_rresp;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) state <= IDLE;
        else              state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_valid ? (cmd_write ? WRITE : READ_AR) : IDLE;
            WRITE:   nxt = ((!awv || M_AXI_awready) && (!wv || M_AXI_wready)) ? WAIT_B : WRITE;
            WAIT_B:  nxt = M_AXI_bvalid ? RESP : WAIT_B;
            READ_AR: nxt = M_AXI_arready ? WAIT_R : READ_AR;
            WAIT_R:  nxt = M_AXI_rvalid ? RESP : WAIT_R;
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            wr        <= 1'b0;
            awv       <= 1'b0;
            wv        <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_count <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr  <= {cmd_addr[ADDR_W-1:2], 2'b00};
                wdata <= cmd_wdata;
                wstrb <= cmd_wstrb;
                wr    <= cmd_write;
                awv   <= cmd_write;
                wv    <= cmd_write;
            end else begin
                // AW and W retire independently; each valid falls right after its own handshake
                if (M_AXI_awready) awv <= 1'b0;
                if (M_AXI_wready)  wv  <= 1'b0;
            end
            if (cap) begin
                rsp_write <= wr;
                rsp_rdata <= b_hs ? '0 : M_AXI_rdata;
                rsp_resp  <= cap_resp;
                if (cap_resp != 2'b00 && !(&err_count)) err_count <= err_count + 1'b1;
            end
        end
    end

    assign cmd_ready     = state == IDLE;
    assign rsp_valid     = state == RESP;
    assign M_AXI_awaddr  = addr;
    assign M_AXI_araddr  = addr;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_wdata   = wdata;
    assign M_AXI_wstrb   = wstrb;
    assign M_AXI_awvalid = awv;
    assign M_AXI_wvalid  = wv;
    assign M_AXI_arvalid = state == READ_AR;
    assign M_AXI_bready  = state == WAIT_B;
    assign M_AXI_rready  = state == WAIT_R;
endmodule

// File: tb/tb_axil_lite_master.sv
// tb_axil_lite_master: directed commands against a delay-configurable AXI4-Lite memory slave;
// expected responses go into a scoreboard queue that a separate monitor drains.
module tb_axil_lite_master;
    localparam int AW = 12;
    localparam int DW = 32;
    // narrow counter so saturation is reachable in a short run
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [EW-1:0] err_count;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic          bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0, rready;

    axil_lite_master #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
    );

    int n_chk = 0, n_fail = 0, n_rsp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          w;
        logic [31:0]   rd;
        logic [1:0]    resp;
        logic [EW-1:0] err;
    } exp_t;
    exp_t sb[$];
    int   err_model = 0;

    task automatic push_exp(input logic w, input logic [31:0] rd, input logic [1:0] rs);
        if (rs != 2'b00 && err_model < (1 << EW) - 1) err_model++;
        sb.push_back(exp_t'{w, rd, rs, err_model[EW-1:0]});
    endtask

    // slave configuration and backing store
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [0:1023];

    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;
    logic [3:0]    w_s;
    always @(posedge clk) begin
        aw_hs <= awvalid && awready;
        w_hs  <= wvalid && wready;
        b_hs  <= bvalid && bready;
        ar_hs <= arvalid && arready;
        r_hs  <= rvalid && rready;
        if (awvalid && awready) aw_a <= awaddr;
        if (wvalid && wready) begin
            w_d <= wdata;
            w_s <= wstrb;
        end
        if (arvalid && arready) ar_a <= araddr;
    end

    initial begin
        int  aw_c, w_c, b_c, ar_c, r_c;
        bit  got_aw, got_w, b_pend, r_pend;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (aw_hs) begin awready = 0; got_aw = 1; aw_c = 0; end
                else if (awvalid && !awready) begin
                    if (aw_c >= aw_dly) awready = 1; else aw_c++;
                end
                if (w_hs) begin wready = 0; got_w = 1; w_c = 0; end
                else if (wvalid && !wready) begin
                    if (w_c >= w_dly) wready = 1; else w_c++;
                end
                if (got_aw && got_w) begin
                    for (int i = 0; i < 4; i++)
                        if (w_s[i]) mem[aw_a[11:2]][8*i +: 8] = w_d[8*i +: 8];
                    got_aw = 0; got_w = 0; b_pend = 1; b_c = 0;
                end
                if (b_hs) bvalid = 0;
                else if (b_pend) begin
                    if (b_c >= b_dly) begin bvalid = 1; bresp = bresp_cfg; b_pend = 0; end
                    else b_c++;
                end
                if (ar_hs) begin arready = 0; ar_c = 0; r_pend = 1; r_c = 0; end
                else if (arvalid && !arready) begin
                    if (ar_c >= ar_dly) arready = 1; else ar_c++;
                end
                if (r_hs) rvalid = 0;
                else if (r_pend) begin
                    if (r_c >= r_dly) begin
                        rvalid = 1; rdata = mem[ar_a[11:2]]; rresp = rresp_cfg; r_pend = 0;
                    end else r_c++;
                end
            end
        end
    end

    // monitor: every accepted response is checked against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                n_rsp++;
                chk("rsp_unexpected", sb.size() == 0, 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_write", rsp_write, e.w);
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("rsp_resp", rsp_resp, e.resp);
                    chk("err_count", err_count, e.err);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int t = 0; t < 100 && !cmd_ready; t++) begin @(posedge clk); #1; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        @(posedge clk); #1;
        for (int t = 0; t < 300 && (sb.size() != 0 || !cmd_ready); t++) begin @(posedge clk); #1; end
        chk("txn_done", sb.size() == 0 && cmd_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rsp0;
        bit  bad;
        logic [31:0] snap_d;
        logic [1:0]  snap_r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err_count, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst_addr_data", {awaddr, araddr, wdata}, 0);
        chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // best-case write, cycle-exact
        push_exp(1, 32'h0, 2'b00);
        issue(1, 12'h040, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("wr_awvalid_n1", awvalid, 1);
        chk("wr_wvalid_n1", wvalid, 1);
        chk("wr_awaddr", awaddr, 12'h040);
        chk("wr_wdata", wdata, 32'hDEADBEEF);
        chk("wr_wstrb", wstrb, 4'hF);
        chk("wr_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk);
        chk("wr_bready_n2", bready, 1);
        chk("wr_awvalid_n2", awvalid, 0);
        @(negedge clk);
        chk("wr_rsp_valid_n3", rsp_valid, 1);
        wait_done();
        chk("mem16", mem[16], 32'hDEADBEEF);

        // read back with unaligned address
        push_exp(0, 32'hDEADBEEF, 2'b00);
        issue(0, 12'h043, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, 12'h040);
        chk("rd_no_aw", awvalid, 0);
        @(negedge clk);
        chk("rd_rready_n2", rready, 1);
        @(negedge clk);
        chk("rd_rsp_valid_n3", rsp_valid, 1);
        wait_done();
        chk("rd_err", err_count, 0);

        // W accepted three cycles before AW, B stalled four cycles
        aw_dly = 3; b_dly = 4;
        rsp0 = n_rsp;
        push_exp(1, 32'h0, 2'b00);
        issue(1, 12'h080, 32'h12345678, 4'b0011);
        @(negedge clk);
        chk("split_both_valid", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        chk("split_w_dropped", {awvalid, wvalid}, 2'b10);
        bad = 0;
        for (int t = 0; t < 30 && !rsp_valid; t++) begin
            bad |= cmd_ready;
            @(negedge clk);
        end
        chk("split_rsp_seen", rsp_valid, 1);
        chk("split_cmd_ready_low", bad, 0);
        wait_done();
        chk("split_one_rsp", n_rsp - rsp0, 1);
        chk("mem32_strobed", mem[32], 32'h00005678);
        aw_dly = 0; b_dly = 0;

        // error responses and saturation
        rresp_cfg = 2'b10;
        push_exp(0, 32'h00005678, 2'b10);
        issue(0, 12'h080, 32'h0, 4'h0);
        wait_done();
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        push_exp(1, 32'h0, 2'b11);
        issue(1, 12'h0C0, 32'hA5A5A5A5, 4'hF);
        wait_done();
        chk("err_two", err_count, 2);
        bresp_cfg = 2'b00; rresp_cfg = 2'b01;
        for (int i = 0; i < 21; i++) begin
            push_exp(0, 32'h00005678, 2'b01);
            issue(0, 12'h080, 32'h0, 4'h0);
            wait_done();
        end
        chk("err_saturated", err_count, 4'hF);
        rresp_cfg = 2'b00;

        // response back-pressure
        rsp_ready = 0;
        push_exp(0, 32'hDEADBEEF, 2'b00);
        issue(0, 12'h040, 32'h0, 4'h0);
        for (int t = 0; t < 30 && !rsp_valid; t++) @(negedge clk);
        chk("stall_rsp_seen", rsp_valid, 1);
        snap_d = rsp_rdata; snap_r = rsp_resp;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            bad |= !rsp_valid || rsp_rdata !== snap_d || rsp_resp !== snap_r || rsp_write !== 1'b0
                 || cmd_ready || awvalid || wvalid || arvalid;
        end
        chk("stall_stable", bad, 0);
        @(posedge clk); #1;
        rsp_ready = 1;
        wait_done();

        // reset while AW is still pending
        aw_dly = 5;
        issue(1, 12'h100, 32'h11111111, 4'hF);
        @(negedge clk);
        chk("rst_mid_awvalid", awvalid, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_err", err_count, 0);
        err_model = 0;
        @(posedge clk); #1;
        rst = 0; aw_dly = 0;
        push_exp(1, 32'h0, 2'b00);
        issue(1, 12'h100, 32'h22222222, 4'hF);
        wait_done();
        chk("post_rst_mem64", mem[64], 32'h22222222);
        chk("post_rst_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
